// File: rtl/controlador_pc_pkg.sv
// Shared types and constants for the program-counter sequencer, the control unit and the branch tester.
package pc_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_RESOLVE
  } state_t;

  typedef enum logic [1:0] {
    SEL_SEQ,
    SEL_IMM,
    SEL_REG
  } pc_sel_t;

  localparam logic [2:0] OP_JCOND   = 3'b101;
  localparam logic [2:0] OP_JUNCOND = 3'b110;
  localparam logic [2:0] OP_JREG    = 3'b111;

  // Branch condition codes evaluated by the branch tester.
  localparam logic [2:0] COND_EQ     = 3'b000;
  localparam logic [2:0] COND_NE     = 3'b001;
  localparam logic [2:0] COND_LT     = 3'b010;
  localparam logic [2:0] COND_GE     = 3'b011;
  localparam logic [2:0] COND_ALWAYS = 3'b100;

  function automatic logic is_jump_op(input logic [2:0] op);
    return (op == OP_JCOND) || (op == OP_JUNCOND) || (op == OP_JREG);
  endfunction

endpackage

// File: rtl/controlador_pc_if.sv
// Handshake and PC bus between the sequencer (master) and UC / imem / branch tester (slave).
// Optional link signals are present when JUMP_LINK_EN is defined.
interface controlador_pc_if #(
  parameter int unsigned ADDR_WIDTH = 16
);
  logic                  Start;
  logic                  Halt;
  logic                  Imem_Read;
  logic                  Imem_Ready;
  logic                  Instr_Valid;
  logic                  Exec_Done;
  logic                  Is_Jump;
  logic [2:0]            Opcode_Jump;
  logic [ADDR_WIDTH-1:0] Jump_Target;
  logic [ADDR_WIDTH-1:0] Reg_Target;
  logic                  Branch;
  logic                  Enable_FontePC;
  logic [ADDR_WIDTH-1:0] PC;
  logic                  Busy;
`ifdef JUMP_LINK_EN
  logic                  Link_Req;
  logic                  Link_Write;
  logic [ADDR_WIDTH-1:0] Link_Addr;
`endif

  modport master (
`ifdef JUMP_LINK_EN
    input  Link_Req,
    output Link_Write, Link_Addr,
`endif
    input  Start, Halt, Imem_Ready, Exec_Done, Is_Jump, Opcode_Jump,
           Jump_Target, Reg_Target, Branch,
    output Imem_Read, Instr_Valid, Enable_FontePC, PC, Busy
  );

  modport slave (
`ifdef JUMP_LINK_EN
    output Link_Req,
    input  Link_Write, Link_Addr,
`endif
    output Start, Halt, Imem_Ready, Exec_Done, Is_Jump, Opcode_Jump,
           Jump_Target, Reg_Target, Branch,
    input  Imem_Read, Instr_Valid, Enable_FontePC, PC, Busy
  );

endinterface

// File: rtl/controlador_pc_proximo.sv
// Combinational next-PC select: sequential (wrapping), immediate target or register target.
module pc_proximo
  import pc_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 16
) (
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic [ADDR_WIDTH-1:0] jump_target,
  input  logic [ADDR_WIDTH-1:0] reg_target,
  input  pc_sel_t               sel,
  output logic [ADDR_WIDTH-1:0] pc_next
);

  always_comb begin
    pc_next = pc + ADDR_WIDTH'(1);
    case (sel)
      SEL_IMM: pc_next = jump_target;
      SEL_REG: pc_next = reg_target;
      default: ;
    endcase
  end

endmodule

// File: rtl/controlador_pc.sv
// Multi-cycle PC sequencer: FETCH / EXEC / RESOLVE FSM owning the architectural PC.
// Define JUMP_LINK_EN to add the link-register write port.
module controlador_pc
  import pc_ctrl_pkg::*;
#(
  parameter int unsigned          ADDR_WIDTH   = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input logic               Clock,
  input logic               Reset_n,
  controlador_pc_if.master  bus
);

  state_t                state, next_state;
  logic [ADDR_WIDTH-1:0] pc, pc_next;
  pc_sel_t               sel;
  logic                  pc_load;
  logic                  imem_read, instr_valid;
  logic                  enable_q;
  logic                  taken;

  // Opcodes outside the jump set never take the branch, whatever the tester says.
  assign taken = bus.Branch && is_jump_op(bus.Opcode_Jump);

  pc_proximo #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_pc_proximo (
    .pc          (pc),
    .jump_target (bus.Jump_Target),
    .reg_target  (bus.Reg_Target),
    .sel         (sel),
    .pc_next     (pc_next)
  );

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= ST_IDLE;
      pc       <= RESET_VECTOR;
      enable_q <= 1'b0;
    end else begin
      state    <= next_state;
      enable_q <= (next_state == ST_RESOLVE);
      if (pc_load) pc <= pc_next;
    end
  end

  always_comb begin
    next_state  = state;
    pc_load     = 1'b0;
    sel         = SEL_SEQ;
    imem_read   = 1'b0;
    instr_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.Start) next_state = ST_FETCH;
      end
      ST_FETCH: begin
        imem_read = 1'b1;
        if (bus.Imem_Ready) begin
          instr_valid = 1'b1;
          next_state  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (bus.Exec_Done) begin
          if (bus.Is_Jump) begin
            next_state = ST_RESOLVE;
          end else begin
            pc_load    = 1'b1;
            next_state = bus.Halt ? ST_IDLE : ST_FETCH;
          end
        end
      end
      ST_RESOLVE: begin
        pc_load = 1'b1;
        if (taken) sel = (bus.Opcode_Jump == OP_JREG) ? SEL_REG : SEL_IMM;
        next_state = bus.Halt ? ST_IDLE : ST_FETCH;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  assign bus.Imem_Read      = imem_read;
  assign bus.Instr_Valid    = instr_valid;
  assign bus.Enable_FontePC = enable_q;
  assign bus.PC             = pc;
  assign bus.Busy           = (state != ST_IDLE);

`ifdef JUMP_LINK_EN
  logic                  link_write;
  logic [ADDR_WIDTH-1:0] link_addr;

  assign link_write = (state == ST_RESOLVE) && bus.Link_Req && taken;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n)        link_addr <= '0;
    else if (link_write) link_addr <= pc + ADDR_WIDTH'(1);
  end

  assign bus.Link_Write = link_write;
  assign bus.Link_Addr  = link_addr;
`endif

endmodule

// File: tb/tb_controlador_pc.sv
// Self-checking bench for controlador_pc: vector table driven through the fetch/exec/resolve handshake,
// fetched PCs scoreboarded against a queue; halt and asynchronous reset as hand-written sequences.
module tb_controlador_pc;
  import pc_ctrl_pkg::*;

  localparam int unsigned AW = 16;

  logic Clock   = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clock = ~Clock;

  controlador_pc_if #(.ADDR_WIDTH(AW)) bus ();

  controlador_pc #(
    .ADDR_WIDTH   (AW),
    .RESET_VECTOR (16'h0000)
  ) dut (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic        is_jump;
    logic [2:0]  opcode;
    logic [15:0] jt;
    logic [15:0] rt;
    logic        branch;
    logic        link;
    logic        halt;
    int unsigned rdly;
    int unsigned edly;
    logic [15:0] exp_pc;
  } vec_t;

  vec_t        vecs[13];
  logic [15:0] sb[$];
  logic [15:0] cur_pc;
  int          checks   = 0;
  int          failures = 0;
  int unsigned cyc      = 0;
  int unsigned last_iv  = 0;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Entered and left 1 time unit after the edge that starts a FETCH cycle.
  task automatic run_vec(input int idx);
    vec_t        v;
    logic [15:0] e;
    v        = vecs[idx];
    bus.Halt = v.halt;
    for (int i = 0; i < int'(v.rdly); i++) begin
      bus.Imem_Ready = 1'b0;
      @(negedge Clock);
      check($sformatf("wait_read[%0d]", idx), 32'(bus.Imem_Read), 1);
      check($sformatf("wait_valid[%0d]", idx), 32'(bus.Instr_Valid), 0);
      tick();
    end
    bus.Imem_Ready = 1'b1;
    sb.push_back(cur_pc);
    @(negedge Clock);
    e = sb.pop_front();
    if (bus.Instr_Valid !== 1'b1) begin
      check($sformatf("instr_valid[%0d]", idx), 32'(bus.Instr_Valid), 1);
    end else begin
      check($sformatf("fetch_pc[%0d]", idx), 32'(bus.PC), 32'(e));
      if (idx == 1 || idx == 2) check($sformatf("iv_gap[%0d]", idx), cyc - last_iv, 2);
      last_iv = cyc;
    end
    tick();
    bus.Imem_Ready = 1'b0;
    for (int i = 0; i < int'(v.edly); i++) tick();
    bus.Exec_Done   = 1'b1;
    bus.Is_Jump     = v.is_jump;
    bus.Opcode_Jump = v.opcode;
    bus.Jump_Target = v.jt;
    bus.Reg_Target  = v.rt;
    @(negedge Clock);
    check($sformatf("exec_read_low[%0d]", idx), 32'(bus.Imem_Read), 0);
    tick();
    bus.Exec_Done = 1'b0;
    bus.Is_Jump   = 1'b0;
    if (v.is_jump) begin
      bus.Branch = v.branch;
`ifdef JUMP_LINK_EN
      bus.Link_Req = v.link;
`endif
      @(negedge Clock);
      check($sformatf("resolve_en[%0d]", idx), 32'(bus.Enable_FontePC), 1);
`ifdef JUMP_LINK_EN
      check($sformatf("link_write[%0d]", idx), 32'(bus.Link_Write), 32'(v.link));
`endif
      tick();
      bus.Branch = 1'b0;
`ifdef JUMP_LINK_EN
      bus.Link_Req = 1'b0;
`endif
      check($sformatf("resolve_en_drop[%0d]", idx), 32'(bus.Enable_FontePC), 0);
    end
    check($sformatf("next_pc[%0d]", idx), 32'(bus.PC), 32'(v.exp_pc));
    if (v.halt) begin
      check($sformatf("halt_busy[%0d]", idx), 32'(bus.Busy), 0);
      check($sformatf("halt_read[%0d]", idx), 32'(bus.Imem_Read), 0);
      bus.Halt = 1'b0;
    end else begin
      check($sformatf("refetch[%0d]", idx), 32'(bus.Imem_Read), 1);
    end
    cur_pc = v.exp_pc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            jump  op      jt        rt        br    lnk   halt  rdly edly exp_pc
    vecs[0]  = '{1'b0, 3'b000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 0, 0, 16'h0001};
    vecs[1]  = '{1'b0, 3'b000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 0, 0, 16'h0002};
    vecs[2]  = '{1'b0, 3'b000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 0, 0, 16'h0003};
    vecs[3]  = '{1'b1, 3'b101, 16'h0040, 16'h0000, 1'b1, 1'b0, 1'b0, 1, 2, 16'h0040};
    vecs[4]  = '{1'b1, 3'b101, 16'h0080, 16'h0000, 1'b0, 1'b0, 1'b0, 0, 0, 16'h0041};
    vecs[5]  = '{1'b1, 3'b111, 16'h0040, 16'h1234, 1'b1, 1'b0, 1'b0, 2, 0, 16'h1234};
    vecs[6]  = '{1'b1, 3'b110, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0, 0, 1, 16'hFFFF};
    vecs[7]  = '{1'b0, 3'b000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 0, 0, 16'h0000};
    vecs[8]  = '{1'b1, 3'b011, 16'h0050, 16'h0060, 1'b1, 1'b0, 1'b0, 0, 0, 16'h0001};
    vecs[9]  = '{1'b1, 3'b110, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0, 0, 0, 16'h0001};
    vecs[10] = '{1'b1, 3'b101, 16'h0010, 16'h0000, 1'b1, 1'b0, 1'b0, 0, 0, 16'h0010};
    vecs[11] = '{1'b1, 3'b110, 16'h0020, 16'h0000, 1'b1, 1'b1, 1'b0, 0, 0, 16'h0020};
    vecs[12] = '{1'b0, 3'b000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 4, 0, 16'h0021};

    bus.Start = 1'b0;        bus.Halt = 1'b0;        bus.Imem_Ready = 1'b0;
    bus.Exec_Done = 1'b0;    bus.Is_Jump = 1'b0;     bus.Opcode_Jump = 3'b000;
    bus.Jump_Target = '0;    bus.Reg_Target = '0;    bus.Branch = 1'b0;
`ifdef JUMP_LINK_EN
    bus.Link_Req = 1'b0;
`endif
    cur_pc = 16'h0000;

    #12;
    check("rst_pc", 32'(bus.PC), 32'h0000);
    check("rst_read", 32'(bus.Imem_Read), 0);
    check("rst_valid", 32'(bus.Instr_Valid), 0);
    check("rst_en", 32'(bus.Enable_FontePC), 0);
    check("rst_busy", 32'(bus.Busy), 0);
`ifdef JUMP_LINK_EN
    check("rst_link_addr", 32'(bus.Link_Addr), 32'h0000);
`endif
    tick();
    Reset_n = 1'b1;
    tick();
    check("idle_busy", 32'(bus.Busy), 0);
    check("idle_read", 32'(bus.Imem_Read), 0);

    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    check("start_busy", 32'(bus.Busy), 1);
    check("start_pc", 32'(bus.PC), 32'h0000);

    for (int i = 0; i < 13; i++) begin
      run_vec(i);
`ifdef JUMP_LINK_EN
      if (i == 11) check("link_addr", 32'(bus.Link_Addr), 32'h0011);
`endif
    end

    // Halted in IDLE: PC holds, nothing requested.
    tick();
    tick();
    check("halt_hold_pc", 32'(bus.PC), 32'h0021);
    check("halt_hold_busy", 32'(bus.Busy), 0);

    // Restart, accept one instruction, then reset asynchronously while in EXEC.
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    check("restart_read", 32'(bus.Imem_Read), 1);
    check("restart_pc", 32'(bus.PC), 32'h0021);
    bus.Imem_Ready = 1'b1;
    tick();
    bus.Imem_Ready = 1'b0;
    check("mid_exec_busy", 32'(bus.Busy), 1);
    #2;
    Reset_n = 1'b0;
    #1;
    check("async_rst_pc", 32'(bus.PC), 32'h0000);
    check("async_rst_read", 32'(bus.Imem_Read), 0);
    check("async_rst_busy", 32'(bus.Busy), 0);
    tick();
    Reset_n = 1'b1;
    tick();
    check("post_rst_busy", 32'(bus.Busy), 0);
    check("post_rst_pc", 32'(bus.PC), 32'h0000);
    check("sb_empty", 32'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
